alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Multi-cycle, parametrised ALU; next generation of the datapath ALU.
- Adds a valid/ready handshake on both sides, registered flags, and iterative shifts (one bit per cycle).
- Adds an iterative shift-add multiplier and correct signed-overflow flags.
- Sits between register-file read and write-back; the core stalls on in_ready/out_valid.

Parameters:
WIDTH, 16, operand/result width in bits (>=4).
SHAMT_W, $clog2(WIDTH), width of shift-amount field.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation request.
in_ready  output  1  block can accept a request.
op  input  4  opcode.
a  input  WIDTH  first operand (Rd).
b  input  WIDTH  second operand (Rs); the shifted operand for shifts.
shamt  input  SHAMT_W  shift amount.
out_valid  output  1  result/flags valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  result.
flag_s, flag_z, flag_c, flag_v  output  1 each  sign, zero, carry, overflow.
err  output  1  illegal or disabled opcode reported with this result.
busy  output  1  state != IDLE.

Behaviour:
- Reset: async clear on rst_n low. State=IDLE; result=0; all flags=0; err=0; out_valid=0; in_ready=1 once rst_n is released.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 CMP: computes a-b; flags only; result=a.
  - 6 MOV: result=b.
  - 7 MUL: low WIDTH bits of a*b, unsigned.
  - 8 SLL, 9 ROL (rotate left), 10 SRL, 11 SRA.
  - 12-15 illegal.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture op/a/b/shamt; go to EXEC, SHIFT or MUL.
  - EXEC: single-cycle ops and illegal opcodes; next cycle -> DONE.
  - SHIFT: one bit per cycle; a down-counter loads shamt. shamt=0 behaves like EXEC (result=b, C=0).
  - MUL: WIDTH iterations, shift-add, one multiplier bit per cycle.
  - DONE: out_valid=1; outputs held stable until out_ready. Then -> IDLE (out_valid=0 the next cycle).
- in_ready=1 only in IDLE; there is no overlap and no input buffering.
- Latency, accept edge to out_valid rising:
  - EXEC ops: 1 cycle.
  - Shifts: max(1, shamt) cycles.
  - MUL: WIDTH+1 cycles.
- Arithmetic is done on WIDTH+1 bits.
  - ADD: C = carry out; V = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB/CMP: C = borrow (a<b unsigned); V = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
- Flags by op class:
  - S = r[msb] for ADD/SUB/CMP, 0 otherwise.
  - Z = (r==0) for all legal ops; for CMP, Z is taken from the difference.
  - Logic ops, MOV, MUL: C=0, V=0.
  - Shifts: C = last bit shifted out (ROL: bit rotated into bit 0); V=0.
- Illegal op: result=0, flags=0, err=1, latency 1.
- out_ready may be high before out_valid; no combinational path from in_valid to out_valid.
- rst_n asserted mid-operation aborts immediately. The pending result is discarded and never presented.

Optional Feature:
ALU_MC_MUL_EN
- Defined: MUL state and the multiplier datapath are compiled in; op 7 behaves as above.
- Undefined: no multiplier logic; op 7 is handled as an illegal opcode (result=0, err=1, latency 1).

Decomposition:
- Package alu_mc_pkg holds:
  - opcode localparams/enum (OP_ADD..OP_SRA);
  - state enum (IDLE, EXEC, SHIFT, MUL, DONE);
  - a flag struct {s,z,c,v}.
- One sub-module, alu_mc_iter: owns the shift/multiply working registers and the iteration counter. Interface is start/done plus the captured operands; the top module owns the FSM and handshake.

Test Plan:
- ADD a=0x7FFF b=0x0001 -> result 0x8000, S=1 Z=0 C=0 V=1, out_valid 1 cycle after accept.
- SUB a=0x0000 b=0x0001 -> 0xFFFF, S=1 C=1 V=0. CMP a=0x1234 b=0x1234 -> result 0x1234, Z=1.
- SRA b=0x8001 shamt=3 -> 0xF000, C=0, out_valid 3 cycles after accept. ROL b=0x8001 shamt=1 -> 0x0003, C=1. SLL shamt=0 b=0x00F0 -> 0x00F0, C=0, latency 1.
- MUL a=0x0012 b=0x0034 -> 0x03A8 after 17 cycles with ALU_MC_MUL_EN defined. Without the macro -> result 0, err=1, latency 1. Op 13 -> err=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, busy=1. Then out_ready=1 -> IDLE and in_ready=1 the next cycle.
- Assert rst_n low 8 cycles into MUL -> all outputs 0 immediately. After release a new ADD 0x0001+0x0001 -> 0x0002 with no stale out_valid.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcodes, FSM states and the flag bundle shared by alu_mc and alu_mc_iter.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_MUL   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Opcodes 8..11 are the four shift/rotate operations.
  function automatic logic is_shift(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one-bit-per-cycle shift and shift-add multiply working registers.
// Multiplier registers exist only when ALU_MC_MUL_EN is defined.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [3:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               done_o,
  output logic [WIDTH-1:0]   res_o,
  output logic               carry_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_s;

  // Returns {bit shifted out (or rotated into bit 0), shifted value}.
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] op, input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    case (op)
      OP_SLL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_SRL:  r = {v[0], 1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  // The first shift happens at start so a shift by n finishes in n cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 4'd0;
      work_q  <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else if (start_i) begin
      op_q    <= op_i;
      work_q  <= a_i;
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      if (is_shift(op_i) && (shamt_i != {SHAMT_W{1'b0}})) begin
        {carry_q, work_q} <= shift_step(op_i, b_i);
        cnt_q             <= CNT_W'(shamt_i) - CNT_ONE;
      end
`ifdef ALU_MC_MUL_EN
      else if (op_i == OP_MUL) begin
        cnt_q <= CNT_W'(WIDTH);
      end
`endif
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_q <= cnt_q - CNT_ONE;
      if (mul_s) begin
        work_q <= {work_q[WIDTH-2:0], 1'b0};
      end else begin
        {carry_q, work_q} <= shift_step(op_q, work_q);
      end
    end
  end

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplier_q;

  assign mul_s = (op_q == OP_MUL);

  // Shift-add: work_q holds the multiplicand shifted left once per iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
    end else if (start_i) begin
      acc_q    <= {WIDTH{1'b0}};
      mplier_q <= b_i;
    end else if (mul_s && (cnt_q != {CNT_W{1'b0}})) begin
      acc_q    <= acc_q + (mplier_q[0] ? work_q : {WIDTH{1'b0}});
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
    end
  end

  assign res_o = mul_s ? acc_q : work_q;
`else
  assign mul_s = 1'b0;
  assign res_o = work_q;
`endif

  assign done_o  = (cnt_q == {CNT_W{1'b0}});
  assign carry_o = carry_q & ~mul_s;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and registered result/flags.
// Define ALU_MC_MUL_EN to build the iterative multiplier (op 7); otherwise op 7 is illegal.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [3:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               flag_s_o,
  output logic               flag_z_o,
  output logic               flag_c_o,
  output logic               flag_v_o,
  output logic               err_o,
  output logic               busy_o
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             in_ready_q, out_valid_q, err_q;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  logic             accept_s, iter_done_s, iter_c_s, err_s;
  logic [WIDTH-1:0] iter_res_s, val_s, res_s;
  logic [WIDTH:0]   sum_s, diff_s;
  flags_t           flags_s;

  assign accept_s = in_valid_i && in_ready_q;

  alu_mc_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept_s),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .shamt_i (shamt_i),
    .done_o  (iter_done_s),
    .res_o   (iter_res_s),
    .carry_o (iter_c_s)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_shift(op_i) && (shamt_i != {SHAMT_W{1'b0}})) state_d = ST_SHIFT;
`ifdef ALU_MC_MUL_EN
          else if (op_i == OP_MUL) state_d = ST_MUL;
`endif
          else state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC:          state_d = ST_DONE;
      ST_SHIFT, ST_MUL: state_d = iter_done_s ? ST_DONE : state_q;
      ST_DONE:          state_d = out_ready_i ? ST_IDLE : ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  assign sum_s  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_s = {1'b0, a_q} - {1'b0, b_q};

  // Result and flags; val_s is the value the flags describe (the difference for CMP).
  always_comb begin
    val_s   = {WIDTH{1'b0}};
    res_s   = {WIDTH{1'b0}};
    flags_s = 4'b0000;
    err_s   = 1'b0;
    case (op_q)
      OP_ADD: begin
        val_s     = sum_s[MSB:0];
        flags_s.c = sum_s[WIDTH];
        flags_s.v = (a_q[MSB] == b_q[MSB]) && (val_s[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        val_s     = diff_s[MSB:0];
        flags_s.c = diff_s[WIDTH];
        flags_s.v = (a_q[MSB] != b_q[MSB]) && (val_s[MSB] != a_q[MSB]);
      end
      OP_AND: val_s = a_q & b_q;
      OP_OR:  val_s = a_q | b_q;
      OP_XOR: val_s = a_q ^ b_q;
      OP_MOV: val_s = b_q;
`ifdef ALU_MC_MUL_EN
      OP_MUL: val_s = iter_res_s;
`else
      OP_MUL: err_s = 1'b1;
`endif
      OP_SLL, OP_ROL, OP_SRL, OP_SRA: begin
        if (state_q == ST_SHIFT) begin
          val_s     = iter_res_s;
          flags_s.c = iter_c_s;
        end else begin
          val_s = b_q;
        end
      end
      default: err_s = 1'b1;
    endcase
    flags_s.s = ((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_CMP)) && val_s[MSB];
    flags_s.z = !err_s && (val_s == {WIDTH{1'b0}});
    res_s     = (op_q == OP_CMP) ? a_q : val_s;
  end

  // State, operand capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 4'd0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      if (accept_s) begin
        op_q <= op_i;
        a_q  <= a_i;
        b_q  <= b_i;
      end
      if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
        result_q <= res_s;
        flags_q  <= flags_s;
        err_q    <= err_s;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign flag_s_o    = flags_q.s;
  assign flag_z_o    = flags_q.z;
  assign flag_c_o    = flags_q.c;
  assign flag_v_o    = flags_q.v;
  assign err_o       = err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed plus randomized checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic [3:0]  shamt = 4'd0;
  logic        in_ready, out_valid, fs, fz, fc, fv, err, busy;
  logic [15:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .shamt_i     (shamt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .flag_s_o    (fs),
    .flag_z_o    (fz),
    .flag_c_o    (fc),
    .flag_v_o    (fv),
    .err_o       (err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model from the instruction definitions; f = {S,Z,C,V}.
  task automatic model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input int n, output logic [15:0] r, output logic [3:0] f,
                       output logic e, output int lat);
    int sr;
    logic [31:0] wide;
    logic [15:0] zv;
    logic s, c, v;
    r = 16'd0; s = 1'b0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1; zv = 16'd0;
    case (o)
      4'd0: begin
        r  = x + y;
        c  = (int'(x) + int'(y)) > 65535;
        sr = int'($signed(x)) + int'($signed(y));
        v  = (sr > 32767) || (sr < -32768);
        s  = r[15]; zv = r;
      end
      4'd1, 4'd5: begin
        zv = x - y;
        c  = x < y;
        sr = int'($signed(x)) - int'($signed(y));
        v  = (sr > 32767) || (sr < -32768);
        s  = zv[15];
        r  = (o == 4'd5) ? x : zv;
      end
      4'd2: begin r = x & y; zv = r; end
      4'd3: begin r = x | y; zv = r; end
      4'd4: begin r = x ^ y; zv = r; end
      4'd6: begin r = y; zv = r; end
`ifdef ALU_MC_MUL_EN
      4'd7: begin
        wide = {16'd0, x} * {16'd0, y};
        r = wide[15:0]; zv = r; lat = 17;
      end
`endif
      4'd8: begin
        r = y << n; c = (n == 0) ? 1'b0 : y[16-n]; zv = r; lat = (n == 0) ? 1 : n;
      end
      4'd9: begin
        r = (y << n) | (y >> (16 - n)); c = (n == 0) ? 1'b0 : r[0]; zv = r; lat = (n == 0) ? 1 : n;
      end
      4'd10: begin
        r = y >> n; c = (n == 0) ? 1'b0 : y[n-1]; zv = r; lat = (n == 0) ? 1 : n;
      end
      4'd11: begin
        r = $signed(y) >>> n; c = (n == 0) ? 1'b0 : y[n-1]; zv = r; lat = (n == 0) ? 1 : n;
      end
      default: e = 1'b1;
    endcase
    f = {s, !e && (zv == 16'd0), c, v};
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [15:0] x,
                     input logic [15:0] y, input logic [3:0] n, input int hold);
    logic [15:0] er;
    logic [3:0]  ef;
    logic        ee;
    int          el, cyc;
    model(o, x, y, int'(n), er, ef, ee, el);
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check({tag, "/ready"}, in_ready, 1);
    op = o; a = x; b = y; shamt = n; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); shamt = 4'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check({tag, "/latency"}, cyc, el);
    check({tag, "/result"}, result, er);
    check({tag, "/flags"}, {fs, fz, fc, fv}, ef);
    check({tag, "/err"}, err, ee);
    check({tag, "/busy_in_ready"}, {busy, in_ready}, 2'b10);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({tag, "/held"}, {out_valid, in_ready, busy, result, fs, fz, fc, fv, err},
            {1'b1, 1'b0, 1'b1, er, ef, ee});
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "/release"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stale;
    #1 rst_n = 1'b0;
    #1;
    check("reset_state", {result, fs, fz, fc, fv, err, out_valid, busy, in_ready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {in_ready, busy, out_valid}, 3'b100);

    run("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 4'd0, 0);
    run("sub_borrow", 4'd1, 16'h0000, 16'h0001, 4'd0, 0);
    run("cmp_equal", 4'd5, 16'h1234, 16'h1234, 4'd0, 0);
    run("sra3", 4'd11, 16'h0000, 16'h8001, 4'd3, 0);
    run("rol1", 4'd9, 16'h0000, 16'h8001, 4'd1, 0);
    run("sll0", 4'd8, 16'h0000, 16'h00F0, 4'd0, 0);
    run("srl15", 4'd10, 16'h0000, 16'h8000, 4'd15, 0);
    run("mul", 4'd7, 16'h0012, 16'h0034, 4'd0, 0);
    run("illegal13", 4'd13, 16'h5555, 16'hAAAA, 4'd0, 0);
    run("backpressure", 4'd0, 16'h1111, 16'h2222, 4'd0, 5);

    // Abort a long operation with reset; the previous result (0x3333) must vanish.
    op = 4'd0; a = 16'h1111; b = 16'h2222;
`ifdef ALU_MC_MUL_EN
    op = 4'd7; a = 16'h00FF; b = 16'h0101;
`else
    op = 4'd10; b = 16'hFFFF; shamt = 4'd15;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("busy_before_abort", {busy, out_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {result, fs, fz, fc, fv, err, out_valid, busy, in_ready}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stale = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("no_stale_valid", stale, 0);
    run("add_after_abort", 4'd0, 16'h0001, 16'h0001, 4'd0, 0);

    for (int i = 0; i < 300; i++) begin
      run($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), pick(), pick(),
          4'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
